// File: rtl/ddr3_refresh_scheduler.sv
// DDR3 refresh scheduler.
// Generates refresh requests from a tREFI interval timer, tracks postponed
// refreshes with a saturating pending counter and holds off all commands for
// tRFC after every refresh the controller actually issues.
module ddr3_refresh_scheduler #(
    parameter int CLK_PERIOD    = 6,
    parameter int TREFI_NS      = 7800,
    parameter int TRFC_NS       = 160,
    parameter int MAX_PENDING   = 9,
    parameter int URGENT_THRESH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init_done,
    input  logic       ref_ack,
    output logic       ref_req,
    output logic       ref_urgent,
    output logic       ref_busy,
    output logic [3:0] pending_cnt,
    output logic       overflow
);

    // tREFI rounds down so refreshes are never issued late; tRFC rounds up so
    // the lockout is never shorter than the DRAM needs.
    localparam int TREFI_CYC = TREFI_NS / CLK_PERIOD;
    localparam int TRFC_CYC  = (TRFC_NS + CLK_PERIOD - 1) / CLK_PERIOD;
    localparam int INT_W     = $clog2(TREFI_CYC);
    localparam int RFC_W     = $clog2(TRFC_CYC + 1);

    logic [INT_W-1:0] int_cnt;
    logic [RFC_W-1:0] rfc_cnt;
    logic [3:0]       pending;
    logic             tick;
    logic             ack_ok;

    assign tick   = init_done && (int_cnt == INT_W'(TREFI_CYC - 1));
    assign ack_ok = ref_ack && ref_req;

    // Interval timer: counts up while initialised, wraps on the tick cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_cnt <= '0;
        end else if (!init_done || tick) begin
            int_cnt <= '0;
        end else begin
            int_cnt <= int_cnt + 1'b1;
        end
    end

    // Pending counter: +1 per tick, -1 per accepted ack, saturating at the top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else if (!init_done) begin
            pending <= '0;
        end else if (tick && !ack_ok) begin
            if (pending != 4'(MAX_PENDING)) begin
                pending <= pending + 1'b1;
            end
        end else if (ack_ok && !tick) begin
            pending <= pending - 1'b1;
        end
    end

    // Sticky overflow: a tick was lost because the counter was already full.
    // Deliberately independent of init_done so the error survives a re-init.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (tick && !ack_ok && (pending == 4'(MAX_PENDING))) begin
            overflow <= 1'b1;
        end
    end

    // tRFC lockout: down-counter loaded on an accepted ack, busy while nonzero.
    // Acks during busy are never accepted, so the window cannot be extended.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rfc_cnt <= '0;
        end else if (ack_ok) begin
            rfc_cnt <= RFC_W'(TRFC_CYC);
        end else if (rfc_cnt != '0) begin
            rfc_cnt <= rfc_cnt - 1'b1;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        ref_busy    = (rfc_cnt != '0);
        ref_req     = (pending != '0) && !ref_busy;
        ref_urgent  = (pending >= 4'(URGENT_THRESH));
        pending_cnt = pending;
    end

endmodule

// File: tb/tb_ddr3_refresh_scheduler.sv
// Directed bench for ddr3_refresh_scheduler with default parameters
// (tREFI = 1300 cycles, tRFC = 27 cycles, saturation 9, urgent at 8).
module tb_ddr3_refresh_scheduler;

    logic       clk;
    logic       reset_n;
    logic       init_done;
    logic       ref_ack;
    logic       ref_req;
    logic       ref_urgent;
    logic       ref_busy;
    logic [3:0] pending_cnt;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    ddr3_refresh_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .init_done   (init_done),
        .ref_ack     (ref_ack),
        .ref_req     (ref_req),
        .ref_urgent  (ref_urgent),
        .ref_busy    (ref_busy),
        .pending_cnt (pending_cnt),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        init_done = 1'b0;
        ref_ack   = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        init_done = 1'b0;
        ref_ack   = 1'b0;
        #1;
        checks++;
        if ({ref_req, ref_urgent, ref_busy, pending_cnt, overflow} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {ref_req, ref_urgent, ref_busy, pending_cnt, overflow});
        end
        cyc(3);
        checks++;
        if ({ref_req, ref_urgent, ref_busy, pending_cnt, overflow} !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: got %b expected 00000000",
                     {ref_req, ref_urgent, ref_busy, pending_cnt, overflow});
        end
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_interval;
        do_reset();
        init_done = 1'b1;
        cyc(1299);
        checks++;
        if (pending_cnt !== 4'd0 || ref_req !== 1'b0) begin
            errors++;
            $display("FAIL interval_pre_tick: pending=%0d req=%0d expected 0/0", pending_cnt, ref_req);
        end
        cyc(1);
        checks++;
        if (pending_cnt !== 4'd1 || ref_req !== 1'b1 || ref_urgent !== 1'b0 || ref_busy !== 1'b0) begin
            errors++;
            $display("FAIL interval_tick1: pending=%0d req=%0d urg=%0d busy=%0d expected 1/1/0/0",
                     pending_cnt, ref_req, ref_urgent, ref_busy);
        end
        cyc(1300);
        checks++;
        if (pending_cnt !== 4'd2) begin
            errors++;
            $display("FAIL interval_tick2: pending=%0d expected 2", pending_cnt);
        end
    endtask

    task automatic test_ack_single;
        int n;
        do_reset();
        init_done = 1'b1;
        cyc(1300);
        ref_ack = 1'b1;
        cyc(1);
        ref_ack = 1'b0;
        checks++;
        if (pending_cnt !== 4'd0 || ref_req !== 1'b0 || ref_busy !== 1'b1) begin
            errors++;
            $display("FAIL ack1_accept: pending=%0d req=%0d busy=%0d expected 0/0/1",
                     pending_cnt, ref_req, ref_busy);
        end
        n = 1;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (ref_busy) n++;
            else break;
        end
        checks++;
        if (n !== 27) begin
            errors++;
            $display("FAIL ack1_busy_len: busy cycles=%0d expected 27", n);
        end
        checks++;
        if (ref_busy !== 1'b0 || ref_req !== 1'b0) begin
            errors++;
            $display("FAIL ack1_after: busy=%0d req=%0d expected 0/0", ref_busy, ref_req);
        end
    endtask

    task automatic test_ack_pending3;
        int n;
        int req_bad;
        do_reset();
        init_done = 1'b1;
        cyc(3900);
        checks++;
        if (pending_cnt !== 4'd3) begin
            errors++;
            $display("FAIL ack3_pre: pending=%0d expected 3", pending_cnt);
        end
        ref_ack = 1'b1;
        cyc(1);
        ref_ack = 1'b0;
        checks++;
        if (pending_cnt !== 4'd2 || ref_busy !== 1'b1 || ref_req !== 1'b0) begin
            errors++;
            $display("FAIL ack3_accept: pending=%0d busy=%0d req=%0d expected 2/1/0",
                     pending_cnt, ref_busy, ref_req);
        end
        n = 1;
        req_bad = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (ref_busy) begin
                n++;
                if (ref_req) req_bad++;
            end else begin
                break;
            end
        end
        checks++;
        if (n !== 27 || req_bad !== 0) begin
            errors++;
            $display("FAIL ack3_busy: busy cycles=%0d req_during_busy=%0d expected 27/0", n, req_bad);
        end
        checks++;
        if (ref_req !== 1'b1 || pending_cnt !== 4'd2) begin
            errors++;
            $display("FAIL ack3_rereq: req=%0d pending=%0d expected 1/2", ref_req, pending_cnt);
        end
    endtask

    task automatic test_saturate;
        do_reset();
        init_done = 1'b1;
        cyc(7 * 1300);
        checks++;
        if (pending_cnt !== 4'd7 || ref_urgent !== 1'b0) begin
            errors++;
            $display("FAIL sat_p7: pending=%0d urg=%0d expected 7/0", pending_cnt, ref_urgent);
        end
        cyc(1300);
        checks++;
        if (pending_cnt !== 4'd8 || ref_urgent !== 1'b1 || ref_req !== 1'b1) begin
            errors++;
            $display("FAIL sat_p8: pending=%0d urg=%0d req=%0d expected 8/1/1",
                     pending_cnt, ref_urgent, ref_req);
        end
        cyc(1300);
        checks++;
        if (pending_cnt !== 4'd9 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_p9: pending=%0d ovf=%0d expected 9/0", pending_cnt, overflow);
        end
        cyc(1299);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_pre_ovf: ovf=%0d expected 0", overflow);
        end
        cyc(1);
        checks++;
        if (pending_cnt !== 4'd9 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf: pending=%0d ovf=%0d expected 9/1", pending_cnt, overflow);
        end
        cyc(1300);
        checks++;
        if (pending_cnt !== 4'd9 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf_hold: pending=%0d ovf=%0d expected 9/1", pending_cnt, overflow);
        end
        init_done = 1'b0;
        cyc(1);
        checks++;
        if (pending_cnt !== 4'd0 || overflow !== 1'b1 || ref_urgent !== 1'b0) begin
            errors++;
            $display("FAIL sat_init_drop: pending=%0d ovf=%0d urg=%0d expected 0/1/0",
                     pending_cnt, overflow, ref_urgent);
        end
    endtask

    task automatic test_tick_ack;
        int n;
        do_reset();
        init_done = 1'b1;
        cyc(3899);
        checks++;
        if (pending_cnt !== 4'd2) begin
            errors++;
            $display("FAIL tickack_pre: pending=%0d expected 2", pending_cnt);
        end
        ref_ack = 1'b1;
        cyc(1);
        ref_ack = 1'b0;
        checks++;
        if (pending_cnt !== 4'd2 || ref_busy !== 1'b1) begin
            errors++;
            $display("FAIL tickack_same: pending=%0d busy=%0d expected 2/1", pending_cnt, ref_busy);
        end
        n = 1;
        for (int i = 0; i < 40; i++) begin
            ref_ack = (n == 5);
            cyc(1);
            ref_ack = 1'b0;
            if (ref_busy) n++;
            else break;
        end
        checks++;
        if (n !== 27) begin
            errors++;
            $display("FAIL tickack_busy_noreload: busy cycles=%0d expected 27", n);
        end
        checks++;
        if (pending_cnt !== 4'd2 || ref_req !== 1'b1) begin
            errors++;
            $display("FAIL tickack_ignored: pending=%0d req=%0d expected 2/1", pending_cnt, ref_req);
        end
    endtask

    task automatic test_init_drop_and_async_reset;
        do_reset();
        init_done = 1'b1;
        cyc(5200 + 300);
        checks++;
        if (pending_cnt !== 4'd4) begin
            errors++;
            $display("FAIL drop_pre: pending=%0d expected 4", pending_cnt);
        end
        init_done = 1'b0;
        cyc(1);
        checks++;
        if (pending_cnt !== 4'd0 || ref_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear: pending=%0d req=%0d expected 0/0", pending_cnt, ref_req);
        end
        init_done = 1'b1;
        cyc(1299);
        checks++;
        if (pending_cnt !== 4'd0) begin
            errors++;
            $display("FAIL drop_restart_pre: pending=%0d expected 0", pending_cnt);
        end
        cyc(1);
        checks++;
        if (pending_cnt !== 4'd1 || ref_req !== 1'b1) begin
            errors++;
            $display("FAIL drop_restart_tick: pending=%0d req=%0d expected 1/1", pending_cnt, ref_req);
        end
        ref_ack = 1'b1;
        cyc(1);
        ref_ack = 1'b0;
        cyc(5);
        checks++;
        if (ref_busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_busy: busy=%0d expected 1", ref_busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ref_busy !== 1'b0 || pending_cnt !== 4'd0 || ref_req !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: busy=%0d pending=%0d req=%0d ovf=%0d expected 0/0/0/0",
                     ref_busy, pending_cnt, ref_req, overflow);
        end
        init_done = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        reset_n   = 1'b1;
        init_done = 1'b0;
        ref_ack   = 1'b0;
        test_reset();
        test_interval();
        test_ack_single();
        test_ack_pending3();
        test_saturate();
        test_tick_ack();
        test_init_drop_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr3_refresh_scheduler.md
Name: ddr3_refresh_scheduler

Overview:
- Generates periodic DRAM refresh requests for ddr3_controller from a tREFI interval timer, counted in user-interface clock cycles.
- Sits directly upstream of the controller's command arbiter.
- Tracks postponed refreshes (JEDEC allows up to 8 outstanding) and escalates to urgent as the limit approaches.
- Enforces the tRFC lockout after each acknowledged refresh.

Parameters:
- CLK_PERIOD, 6, UI clock period in ns (DDR period 3 ns x 2:1 ratio).
- TREFI_NS, 7800, average refresh interval in ns.
- TRFC_NS, 160, refresh cycle time in ns.
- MAX_PENDING, 9, saturation value of the pending counter.
- URGENT_THRESH, 8, pending count at which ref_urgent asserts.
- Derived: TREFI_CYC = floor(TREFI_NS/CLK_PERIOD) = 1300; TRFC_CYC = ceil(TRFC_NS/CLK_PERIOD) = 27.

Ports:
- clk  in  1  UI clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- init_done  in  1  DRAM initialisation complete; enables scheduling.
- ref_ack  in  1  controller has issued REF this cycle.
- ref_req  out  1  refresh wanted.
- ref_urgent  out  1  pending >= URGENT_THRESH; arbiter must prioritise REF.
- ref_busy  out  1  tRFC window active; no commands to DRAM.
- pending_cnt  out  4  outstanding refresh count (0..MAX_PENDING).
- overflow  out  1  sticky error: tick arrived while pending already at MAX_PENDING.

Behaviour:
- Reset: all outputs 0, interval counter 0, pending 0, tRFC counter 0, overflow 0.
- Interval counter:
  - Runs only while init_done=1; counts 0..TREFI_CYC-1, then wraps to 0.
  - The wrap cycle produces one "tick".
  - The first tick occurs TREFI_CYC cycles after init_done first samples 1.
- init_done deasserted: interval counter and pending cleared synchronously on the next edge; ref_req drops; the tRFC timer and overflow are unaffected.
- ref_req = (pending != 0) && !ref_busy. Combinational from registers; no dependence on ref_ack.
- ref_ack:
  - Accepted only in a cycle where ref_req=1; otherwise ignored (no state change).
  - On accept: pending decrements on that edge, and the tRFC counter loads TRFC_CYC.
- ref_busy is high for exactly TRFC_CYC cycles, starting the cycle after the accepted ack. ref_req is forced low throughout.
- Simultaneous tick and accepted ack: pending unchanged (+1 -1).
- Tick with pending = MAX_PENDING and no accepted ack: pending stays at MAX_PENDING and overflow sets. overflow is cleared only by reset.
- ref_urgent = pending >= URGENT_THRESH, registered-state combinational.
- Reset mid-tRFC or mid-interval: everything returns to reset values immediately (asynchronous assert); release is synchronous to clk.
- No latency beyond one clock from any event to the pending/busy update.

Test Plan:
- Reset, init_done=1 at cycle 0, ref_ack tied 0 -> pending_cnt=1 and ref_req=1 at cycle 1300; pending_cnt=2 at cycle 2600.
- Pending=1, pulse ref_ack one cycle -> pending_cnt=0 and ref_req=0 next cycle; ref_busy=1 for exactly 27 cycles, then 0.
- Pending=3, ack accepted -> busy for 27 cycles with ref_req=0; ref_req=1 again on cycle 28 (pending=2).
- No acks for 8 ticks -> ref_urgent=1 at pending=8. 9th tick gives pending=9. 10th tick -> overflow=1, pending stays 9, overflow held until reset.
- Ack on the same cycle as a tick with pending=2 -> pending stays 2, busy starts. Ack while ref_busy=1 -> ignored, busy count not reloaded.
- Drop init_done with pending=4 mid-interval -> pending=0, ref_req=0 next cycle. Assert reset_n=0 mid-tRFC -> ref_busy=0 immediately.
